// File: rtl/smoldvi_pkg.sv
// Shared smoldvi definitions: link-state encoding, default timing constants
// and the per-state lane control decode used by the link sequencer.
package smoldvi_pkg;

    localparam logic [2:0] ST_OFF      = 3'd0;
    localparam logic [2:0] ST_RESET    = 3'd1;
    localparam logic [2:0] ST_CLK_ONLY = 3'd2;
    localparam logic [2:0] ST_BLANK    = 3'd3;
    localparam logic [2:0] ST_ACTIVE   = 3'd4;
    localparam logic [2:0] ST_DRAIN    = 3'd5;

    localparam int DEF_RST_HOLD     = 16;
    localparam int DEF_CLK_LEAD     = 1024;
    localparam int DEF_HPD_DEBOUNCE = 4096;
    localparam int DEF_DRAIN_MAX    = 1048576;

    typedef enum logic [2:0] {
        S_OFF      = ST_OFF,
        S_RESET    = ST_RESET,
        S_CLK_ONLY = ST_CLK_ONLY,
        S_BLANK    = ST_BLANK,
        S_ACTIVE   = ST_ACTIVE,
        S_DRAIN    = ST_DRAIN
    } link_state_t;

    typedef struct packed {
        logic ser_rst_n;
        logic clk_lane_en;
        logic data_lane_en;
        logic force_blank;
        logic link_up;
    } lane_ctrl_t;

    function automatic lane_ctrl_t state_ctrl(input link_state_t s);
        lane_ctrl_t c;
        c = '{ser_rst_n: 1'b0, clk_lane_en: 1'b0, data_lane_en: 1'b0,
              force_blank: 1'b1, link_up: 1'b0};
        case (s)
            S_CLK_ONLY: c = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
            S_BLANK:    c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            S_ACTIVE:   c = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
            S_DRAIN:    c = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
            default:    c = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        endcase
        return c;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/smoldvi_hpd_debounce.sv
// Hot-plug detect conditioning: 2-flop synchroniser followed by a debounce
// counter that only accepts a level change held for HPD_DEBOUNCE cycles.
module smoldvi_hpd_debounce
    import smoldvi_pkg::*;
#(
    parameter int HPD_DEBOUNCE = DEF_HPD_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic hpd_raw,
    output logic hpd_ok
);

    localparam int CW = $clog2(HPD_DEBOUNCE + 1);

    logic          sync_a;
    logic          sync_b;
    logic [CW-1:0] cnt;

    // The count reaches HPD_DEBOUNCE after that many differing cycles; the
    // output flips on the following edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            cnt    <= '0;
            hpd_ok <= 1'b0;
        end else begin
            sync_a <= hpd_raw;
            sync_b <= sync_a;
            if (sync_b == hpd_ok) begin
                cnt <= '0;
            end else if (cnt == CW'(HPD_DEBOUNCE)) begin
                hpd_ok <= sync_b;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/smoldvi_link_seq.sv
// DVI link power sequencer: orders serialiser reset, clock lane, blanking and
// frame-aligned video, and tears the link down at a frame boundary.
module smoldvi_link_seq
    import smoldvi_pkg::*;
#(
    parameter int RST_HOLD     = DEF_RST_HOLD,
    parameter int CLK_LEAD     = DEF_CLK_LEAD,
    parameter int HPD_DEBOUNCE = DEF_HPD_DEBOUNCE,
    parameter int DRAIN_MAX    = DEF_DRAIN_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic hpd_raw,
    input  logic frame_start,
    output logic ser_rst_n,
    output logic clk_lane_en,
    output logic data_lane_en,
    output logic force_blank,
    output logic link_up,
    output logic hpd_ok
);

    localparam int MAXP = max3(RST_HOLD, CLK_LEAD, DRAIN_MAX);
    localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

    localparam logic [CW-1:0] RST_LOAD   = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] CLK_LOAD   = CW'(CLK_LEAD - 1);
    localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_MAX - 1);

    link_state_t   state;
    lane_ctrl_t    ctrl;
    logic [CW-1:0] cnt;
    logic          req;

    smoldvi_hpd_debounce #(
        .HPD_DEBOUNCE (HPD_DEBOUNCE)
    ) u_hpd (
        .clk     (clk),
        .rst     (rst),
        .hpd_raw (hpd_raw),
        .hpd_ok  (hpd_ok)
    );

    assign req = enable & hpd_ok;

    // Outputs are decoded from the state being entered so they change on the
    // same edge as the transition. Counter is loaded with duration-1 on entry
    // and the state exits on the edge where it is already zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_OFF;
            ctrl  <= state_ctrl(S_OFF);
            cnt   <= '0;
        end else begin
            case (state)
                S_OFF: begin
                    if (req) begin
                        state <= S_RESET;
                        ctrl  <= state_ctrl(S_RESET);
                        cnt   <= RST_LOAD;
                    end
                end
                S_RESET: begin
                    if (!req) begin
                        state <= S_OFF;
                        ctrl  <= state_ctrl(S_OFF);
                    end else if (cnt == '0) begin
                        state <= S_CLK_ONLY;
                        ctrl  <= state_ctrl(S_CLK_ONLY);
                        cnt   <= CLK_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_CLK_ONLY: begin
                    if (!req) begin
                        state <= S_OFF;
                        ctrl  <= state_ctrl(S_OFF);
                    end else if (cnt == '0) begin
                        state <= S_BLANK;
                        ctrl  <= state_ctrl(S_BLANK);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_BLANK: begin
                    if (!req) begin
                        state <= S_OFF;
                        ctrl  <= state_ctrl(S_OFF);
                    end else if (frame_start) begin
                        state <= S_ACTIVE;
                        ctrl  <= state_ctrl(S_ACTIVE);
                    end
                end
                S_ACTIVE: begin
                    if (!req) begin
                        state <= S_DRAIN;
                        ctrl  <= state_ctrl(S_DRAIN);
                        cnt   <= DRAIN_LOAD;
                    end
                end
                S_DRAIN: begin
                    // req is ignored here: a drain always completes through OFF.
                    if (frame_start || cnt == '0) begin
                        state <= S_OFF;
                        ctrl  <= state_ctrl(S_OFF);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_OFF;
                    ctrl  <= state_ctrl(S_OFF);
                end
            endcase
        end
    end

    assign ser_rst_n    = ctrl.ser_rst_n;
    assign clk_lane_en  = ctrl.clk_lane_en;
    assign data_lane_en = ctrl.data_lane_en;
    assign force_blank  = ctrl.force_blank;
    assign link_up      = ctrl.link_up;

endmodule

// File: tb/tb_smoldvi_link_seq.sv
// Directed bench for smoldvi_link_seq with small timing parameters.
module tb_smoldvi_link_seq;

    logic clk;
    logic rst;
    logic enable;
    logic hpd_raw;
    logic frame_start;
    logic ser_rst_n;
    logic clk_lane_en;
    logic data_lane_en;
    logic force_blank;
    logic link_up;
    logic hpd_ok;

    int tests_run;
    int tests_failed;

    // {ser_rst_n, clk_lane_en, data_lane_en, force_blank, link_up, hpd_ok}
    logic [5:0] outs;
    assign outs = {ser_rst_n, clk_lane_en, data_lane_en, force_blank, link_up, hpd_ok};

    localparam logic [5:0] O_RST      = 6'b000100;
    localparam logic [5:0] O_OFF      = 6'b000101;
    localparam logic [5:0] O_CLK      = 6'b110101;
    localparam logic [5:0] O_BLANK    = 6'b111101;
    localparam logic [5:0] O_ACTIVE   = 6'b111011;
    localparam logic [5:0] O_CLK_NOHP = 6'b110100;

    smoldvi_link_seq #(
        .RST_HOLD     (4),
        .CLK_LEAD     (8),
        .HPD_DEBOUNCE (16),
        .DRAIN_MAX    (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .hpd_raw      (hpd_raw),
        .frame_start  (frame_start),
        .ser_rst_n    (ser_rst_n),
        .clk_lane_en  (clk_lane_en),
        .data_lane_en (data_lane_en),
        .force_blank  (force_blank),
        .link_up      (link_up),
        .hpd_ok       (hpd_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bring_up();
        enable = 1'b1;
        repeat (13) tick();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (outs !== O_RST) begin tests_failed++; $display("FAIL reset_held: got %b expected %b", outs, O_RST); end
        rst = 1'b0;
        tick();
        tests_run++;
        if (outs !== O_RST) begin tests_failed++; $display("FAIL reset_released: got %b expected %b", outs, O_RST); end
    endtask

    task automatic test_hpd_glitch();
        hpd_raw = 1'b1;
        repeat (10) tick();
        hpd_raw = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            tests_run++;
            if (hpd_ok !== 1'b0) begin tests_failed++; $display("FAIL hpd_glitch_%0d: got %b expected 0", i, hpd_ok); end
        end
        hpd_raw = 1'b1;
        repeat (18) tick();
        tests_run++;
        if (hpd_ok !== 1'b0) begin tests_failed++; $display("FAIL hpd_early: got %b expected 0", hpd_ok); end
        tick();
        tests_run++;
        if (hpd_ok !== 1'b1) begin tests_failed++; $display("FAIL hpd_rise: got %b expected 1", hpd_ok); end
    endtask

    task automatic test_bringup();
        enable = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (i == 4) begin
                tests_run++;
                if (outs !== O_OFF) begin tests_failed++; $display("FAIL bringup_reset_hold: got %b expected %b", outs, O_OFF); end
            end
            if (i == 5) begin
                tests_run++;
                if (outs !== O_CLK) begin tests_failed++; $display("FAIL bringup_clk_only: got %b expected %b", outs, O_CLK); end
            end
            if (i == 12) begin
                tests_run++;
                if (outs !== O_CLK) begin tests_failed++; $display("FAIL bringup_clk_lead: got %b expected %b", outs, O_CLK); end
                frame_start = 1'b1;
            end
            if (i == 13) begin
                frame_start = 1'b0;
                tests_run++;
                if (outs !== O_BLANK) begin tests_failed++; $display("FAIL bringup_blank: got %b expected %b", outs, O_BLANK); end
            end
        end
        repeat (2) tick();
        tests_run++;
        if (outs !== O_BLANK) begin tests_failed++; $display("FAIL bringup_entry_frame_ignored: got %b expected %b", outs, O_BLANK); end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tests_run++;
        if (outs !== O_ACTIVE) begin tests_failed++; $display("FAIL bringup_active: got %b expected %b", outs, O_ACTIVE); end
    endtask

    task automatic test_teardown_frame();
        enable = 1'b0;
        tick();
        tests_run++;
        if (outs !== O_BLANK) begin tests_failed++; $display("FAIL teardown_drain: got %b expected %b", outs, O_BLANK); end
        repeat (3) tick();
        tests_run++;
        if (outs !== O_BLANK) begin tests_failed++; $display("FAIL teardown_drain_hold: got %b expected %b", outs, O_BLANK); end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tests_run++;
        if (outs !== O_OFF) begin tests_failed++; $display("FAIL teardown_off: got %b expected %b", outs, O_OFF); end
    endtask

    task automatic test_teardown_timeout();
        bring_up();
        tests_run++;
        if (outs !== O_ACTIVE) begin tests_failed++; $display("FAIL timeout_pre_active: got %b expected %b", outs, O_ACTIVE); end
        enable = 1'b0;
        tick();
        repeat (31) tick();
        tests_run++;
        if (outs !== O_BLANK) begin tests_failed++; $display("FAIL timeout_drain_31: got %b expected %b", outs, O_BLANK); end
        tick();
        tests_run++;
        if (outs !== O_OFF) begin tests_failed++; $display("FAIL timeout_off_32: got %b expected %b", outs, O_OFF); end
    endtask

    task automatic test_abort_clk_only();
        // hpd_ok falls 19 edges after hpd_raw, landing on CLK_ONLY's last cycle.
        hpd_raw = 1'b0;
        repeat (7) tick();
        enable = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick();
            if (i == 5 || i == 11) begin
                tests_run++;
                if (outs !== O_CLK) begin tests_failed++; $display("FAIL abort_clk_only_%0d: got %b expected %b", i, outs, O_CLK); end
            end
            if (i == 12) begin
                tests_run++;
                if (outs !== O_CLK_NOHP) begin tests_failed++; $display("FAIL abort_hpd_drop: got %b expected %b", outs, O_CLK_NOHP); end
            end
            if (i == 13) begin
                tests_run++;
                if (outs !== O_RST) begin tests_failed++; $display("FAIL abort_off: got %b expected %b", outs, O_RST); end
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (outs !== O_RST) begin tests_failed++; $display("FAIL abort_stay_off_%0d: got %b expected %b", i, outs, O_RST); end
        end
        enable = 1'b0;
        hpd_raw = 1'b1;
        repeat (20) tick();
        tests_run++;
        if (hpd_ok !== 1'b1) begin tests_failed++; $display("FAIL abort_hpd_restore: got %b expected 1", hpd_ok); end
    endtask

    task automatic test_drain_reassert();
        bring_up();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (outs !== O_BLANK) begin tests_failed++; $display("FAIL reassert_stays_drain: got %b expected %b", outs, O_BLANK); end
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tests_run++;
        if (outs !== O_OFF) begin tests_failed++; $display("FAIL reassert_off: got %b expected %b", outs, O_OFF); end
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i == 4) begin
                tests_run++;
                if (outs !== O_OFF) begin tests_failed++; $display("FAIL reassert_reset_hold: got %b expected %b", outs, O_OFF); end
            end
            if (i == 5) begin
                tests_run++;
                if (outs !== O_CLK) begin tests_failed++; $display("FAIL reassert_clk_only: got %b expected %b", outs, O_CLK); end
            end
        end
    endtask

    task automatic test_rst_active();
        enable = 1'b0;
        tick();
        tests_run++;
        if (outs !== O_OFF) begin tests_failed++; $display("FAIL rst_pre_off: got %b expected %b", outs, O_OFF); end
        bring_up();
        tests_run++;
        if (outs !== O_ACTIVE) begin tests_failed++; $display("FAIL rst_pre_active: got %b expected %b", outs, O_ACTIVE); end
        rst = 1'b1;
        tick();
        tests_run++;
        if (outs !== O_RST) begin tests_failed++; $display("FAIL rst_in_active: got %b expected %b", outs, O_RST); end
        rst = 1'b0;
        tick();
        tests_run++;
        if (outs !== O_RST) begin tests_failed++; $display("FAIL rst_after_release: got %b expected %b", outs, O_RST); end
        enable = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        enable       = 1'b0;
        hpd_raw      = 1'b0;
        frame_start  = 1'b0;
        test_reset();
        test_hpd_glitch();
        test_bringup();
        test_teardown_frame();
        test_teardown_timeout();
        test_abort_clk_only();
        test_drain_reassert();
        test_rst_active();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
